// File: rtl/fft_frame_serializer.sv
`default_nettype none
// ============================================================================
// Module      : fft_frame_serializer
// Description : Captures a parallel FFT result frame in one cycle into one of
//               two ping-pong banks and streams it out one bin per cycle over
//               a valid/ready interface, optionally undoing bit-reversed order.
//               Frames arriving while both banks are full are dropped and
//               counted.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_frame_serializer #(
    parameter int DATA_WIDTH     = 50,
    parameter int N_POINTS       = 8,
    parameter int BIT_REVERSE    = 1,
    parameter int DROP_CNT_WIDTH = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        frame_valid_i,
    input  logic [DATA_WIDTH-1:0]       frame_i [0:N_POINTS-1],
    output logic                        frame_ready_o,
    output logic                        frame_drop_o,
    output logic [DROP_CNT_WIDTH-1:0]   drop_count_o,
    output logic                        m_valid_o,
    input  logic                        m_ready_i,
    output logic [DATA_WIDTH-1:0]       m_data_o,
    output logic [$clog2(N_POINTS)-1:0] m_index_o,
    output logic                        m_last_o
);

    localparam int IDX_W = $clog2(N_POINTS);
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(N_POINTS - 1);

    // Ping-pong frame storage; contents are never reset.
    logic [DATA_WIDTH-1:0]     bank_q [0:1][0:N_POINTS-1];

    logic                      wr_ptr_q, wr_ptr_d;
    logic                      rd_ptr_q, rd_ptr_d;
    logic [1:0]                count_q, count_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic                      drop_q, drop_d;
    logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

    logic                      w_capture;
    logic                      w_drop;
    logic                      w_beat;
    logic                      w_last_beat;
    logic [IDX_W-1:0]          w_rd_addr;

    // Ready depends on the occupancy register only, so a frame offered while
    // both banks are full is dropped even if the last beat drains one bank
    // in that same cycle.
    assign frame_ready_o = (count_q < 2'd2);
    assign m_valid_o     = (count_q != 2'd0);

    assign w_capture   = frame_valid_i && frame_ready_o;
    assign w_drop      = frame_valid_i && !frame_ready_o;
    assign w_beat      = m_valid_o && m_ready_i;
    assign w_last_beat = w_beat && (idx_q == C_LAST_IDX);

    // Read address: either the bit-reversed bin index or the index itself.
    generate
        if (BIT_REVERSE != 0) begin : g_bitrev
            for (genvar b = 0; b < IDX_W; b++) begin : g_bit
                assign w_rd_addr[b] = idx_q[IDX_W-1-b];
            end
        end else begin : g_natural
            assign w_rd_addr = idx_q;
        end
    endgenerate

    // Stream outputs are zeroed whenever no bin is being presented.
    assign m_data_o     = m_valid_o ? bank_q[rd_ptr_q][w_rd_addr] : '0;
    assign m_index_o    = m_valid_o ? idx_q : '0;
    assign m_last_o     = m_valid_o && (idx_q == C_LAST_IDX);
    assign frame_drop_o = drop_q;
    assign drop_count_o = drop_cnt_q;

    // Next-state logic for pointers, occupancy, bin index and drop tracking.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        idx_d      = idx_q;
        drop_d     = w_drop;
        drop_cnt_d = drop_cnt_q;

        if (w_capture) begin
            wr_ptr_d = ~wr_ptr_q;
        end

        if (w_last_beat) begin
            idx_d    = '0;
            rd_ptr_d = ~rd_ptr_q;
        end else if (w_beat) begin
            idx_d = idx_q + 1'b1;
        end

        if (w_capture && !w_last_beat) begin
            count_d = count_q + 2'd1;
        end else if (!w_capture && w_last_beat) begin
            count_d = count_q - 2'd1;
        end

        if (w_drop && (drop_cnt_q != {DROP_CNT_WIDTH{1'b1}})) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            idx_q      <= '0;
            drop_q     <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            drop_q     <= drop_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Whole-frame capture into the free bank.
    always_ff @(posedge clk_i) begin
        if (w_capture) begin
            for (int i = 0; i < N_POINTS; i++) begin
                bank_q[wr_ptr_q][i] <= frame_i[i];
            end
        end
    end

endmodule
`default_nettype wire
